// File: rtl/power_pellet_ctrl_if.sv
// Game-side bundle for the power pellet controller: pellet/Pac-Man
// coordinates and control pulses in, pellet visibility and frightened-mode status out.
interface power_pellet_ctrl_if #(
    parameter int NUM_DOTS = 4,
    parameter int COORD_W  = 10
);
    localparam int IDX_W     = (NUM_DOTS > 1) ? $clog2(NUM_DOTS) : 1;
    localparam int CNT_OUT_W = $clog2(NUM_DOTS + 1);

    logic [NUM_DOTS*COORD_W-1:0] dotX;
    logic [NUM_DOTS*COORD_W-1:0] dotY;
    logic [COORD_W-1:0]          pacX;
    logic [COORD_W-1:0]          pacY;
    logic                        pause;
    logic                        level_restart;
    logic [NUM_DOTS-1:0]         show;
    logic                        freeze;
    logic                        warn;
    logic                        eat_pulse;
    logic [IDX_W-1:0]            eat_index;
    logic [CNT_OUT_W-1:0]        eat_count;
    logic                        all_eaten;

    modport master (
        output dotX, dotY, pacX, pacY, pause, level_restart,
        input  show, freeze, warn, eat_pulse, eat_index, eat_count, all_eaten
    );

    modport slave (
        input  dotX, dotY, pacX, pacY, pause, level_restart,
        output show, freeze, warn, eat_pulse, eat_index, eat_count, all_eaten
    );
endinterface

// File: rtl/power_pellet_ctrl.sv
// Power pellet controller: hides pellets Pac-Man touches and runs the
// frightened-mode timer (FRIGHT then WARN) that freezes the ghosts.
module power_pellet_ctrl #(
    parameter int NUM_DOTS      = 4,
    parameter int COORD_W       = 10,
    parameter int HIT_RADIUS    = 6,
    parameter int CNT_W         = 28,
    parameter int FRIGHT_CYCLES = 268435455,
    parameter int WARN_CYCLES   = 50000000
) (
    input  logic                  Clk,
    input  logic                  Reset,
    power_pellet_ctrl_if.slave    bus
);
    localparam int IDX_W     = (NUM_DOTS > 1) ? $clog2(NUM_DOTS) : 1;
    localparam int CNT_OUT_W = $clog2(NUM_DOTS + 1);

    localparam logic [CNT_W-1:0]   FRIGHT_LOAD = CNT_W'(FRIGHT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   WARN_LIMIT  = CNT_W'(WARN_CYCLES);
    localparam logic [COORD_W:0]   RADIUS      = (COORD_W + 1)'(HIT_RADIUS);
    localparam logic [CNT_W-1:0]   CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FRIGHT = 2'd1,
        S_WARN   = 2'd2
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [NUM_DOTS-1:0]    show_q;
    logic                   freeze_q;
    logic                   warn_q;
    logic                   eat_pulse_q;
    logic [IDX_W-1:0]       eat_index_q;
    logic [CNT_OUT_W-1:0]   eat_count_q;
    logic                   all_eaten_q;

    logic [NUM_DOTS-1:0]    hit_d;
    logic [NUM_DOTS-1:0]    show_d;
    logic                   any_hit_d;
    logic [IDX_W-1:0]       hit_idx_d;
    logic [CNT_OUT_W-1:0]   hit_cnt_d;
    logic [CNT_W-1:0]       cnt_dec_d;

    // One extra bit keeps the subtraction from wrapping, so pellets near
    // opposite screen edges never alias into a hit.
    function automatic logic [COORD_W:0] abs_diff(
        input logic [COORD_W-1:0] a,
        input logic [COORD_W-1:0] b
    );
        logic [COORD_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[COORD_W]) begin
            abs_diff = -d;
        end else begin
            abs_diff = d;
        end
    endfunction

    // Per-pellet collision window test against Pac-Man's centre.
    always_comb begin
        hit_d = {NUM_DOTS{1'b0}};
        for (int i = 0; i < NUM_DOTS; i++) begin
            hit_d[i] = show_q[i] & ~bus.pause & ~bus.level_restart
                     & (abs_diff(bus.dotX[i*COORD_W +: COORD_W], bus.pacX) <= RADIUS)
                     & (abs_diff(bus.dotY[i*COORD_W +: COORD_W], bus.pacY) <= RADIUS);
        end
    end

    // Lowest colliding index and number of simultaneous collisions.
    always_comb begin
        hit_idx_d = {IDX_W{1'b0}};
        hit_cnt_d = {CNT_OUT_W{1'b0}};
        for (int i = NUM_DOTS - 1; i >= 0; i--) begin
            if (hit_d[i]) begin
                hit_idx_d = IDX_W'(i);
            end else begin
                hit_idx_d = hit_idx_d;
            end
            hit_cnt_d = hit_cnt_d + CNT_OUT_W'(hit_d[i]);
        end
    end

    // Derived next values shared by the sequential block.
    always_comb begin
        any_hit_d = |hit_d;
        show_d    = show_q & ~hit_d;
        cnt_dec_d = cnt_q - CNT_ONE;
    end

    // Pellet visibility, eat reporting and frightened-mode state machine.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= CNT_ZERO;
            show_q      <= {NUM_DOTS{1'b1}};
            freeze_q    <= 1'b0;
            warn_q      <= 1'b0;
            eat_pulse_q <= 1'b0;
            eat_index_q <= {IDX_W{1'b0}};
            eat_count_q <= {CNT_OUT_W{1'b0}};
            all_eaten_q <= 1'b0;
        end else if (bus.level_restart) begin
            state_q     <= S_IDLE;
            cnt_q       <= CNT_ZERO;
            show_q      <= {NUM_DOTS{1'b1}};
            freeze_q    <= 1'b0;
            warn_q      <= 1'b0;
            eat_pulse_q <= 1'b0;
            eat_count_q <= {CNT_OUT_W{1'b0}};
            all_eaten_q <= 1'b0;
        end else if (bus.pause) begin
            eat_pulse_q <= 1'b0;
            eat_count_q <= {CNT_OUT_W{1'b0}};
        end else begin
            show_q      <= show_d;
            all_eaten_q <= (show_d == {NUM_DOTS{1'b0}});
            eat_pulse_q <= any_hit_d;
            eat_count_q <= hit_cnt_d;
            if (any_hit_d) begin
                // Any eat, including a re-eat mid-warning, restarts a full period.
                eat_index_q <= hit_idx_d;
                state_q     <= S_FRIGHT;
                cnt_q       <= FRIGHT_LOAD;
                freeze_q    <= 1'b1;
                warn_q      <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        freeze_q <= 1'b0;
                        warn_q   <= 1'b0;
                    end
                    S_FRIGHT: begin
                        if (cnt_q == CNT_ZERO) begin
                            state_q  <= S_IDLE;
                            freeze_q <= 1'b0;
                            warn_q   <= 1'b0;
                        end else begin
                            cnt_q <= cnt_dec_d;
                            if (cnt_dec_d < WARN_LIMIT) begin
                                state_q <= S_WARN;
                                warn_q  <= 1'b1;
                            end else begin
                                warn_q  <= 1'b0;
                            end
                        end
                    end
                    S_WARN: begin
                        if (cnt_q == CNT_ZERO) begin
                            state_q  <= S_IDLE;
                            freeze_q <= 1'b0;
                            warn_q   <= 1'b0;
                        end else begin
                            cnt_q <= cnt_dec_d;
                        end
                    end
                    default: begin
                        state_q  <= S_IDLE;
                        cnt_q    <= CNT_ZERO;
                        freeze_q <= 1'b0;
                        warn_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.show      = show_q;
    assign bus.freeze    = freeze_q;
    assign bus.warn      = warn_q;
    assign bus.eat_pulse = eat_pulse_q;
    assign bus.eat_index = eat_index_q;
    assign bus.eat_count = eat_count_q;
    assign bus.all_eaten = all_eaten_q;
endmodule

// File: tb/tb_power_pellet_ctrl.sv
// Bench for power_pellet_ctrl: directed scenarios plus random play, checked
// every cycle against a remaining-frightened-time model of the game rules.
module tb_power_pellet_ctrl;
    localparam int ND    = 4;
    localparam int CW    = 10;
    localparam int R     = 6;
    localparam int CNTW  = 28;
    localparam int F     = 20;
    localparam int W     = 5;
    localparam logic [CW-1:0] PARK = 10'd900;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    power_pellet_ctrl_if #(.NUM_DOTS(ND), .COORD_W(CW)) bus ();

    power_pellet_ctrl #(
        .NUM_DOTS(ND), .COORD_W(CW), .HIT_RADIUS(R), .CNT_W(CNTW),
        .FRIGHT_CYCLES(F), .WARN_CYCLES(W)
    ) dut (
        .Clk(clk),
        .Reset(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: visible set plus number of frightened cycles still to run.
    logic [ND-1:0] m_show;
    int            m_left;
    int            m_pulse;
    int            m_idx;
    int            m_cnt;
    int            m_all;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_dot(input int i, input int x, input int y);
        bus.dotX[i*CW +: CW] = CW'(x);
        bus.dotY[i*CW +: CW] = CW'(y);
    endtask

    task automatic set_pac(input int x, input int y);
        bus.pacX = CW'(x);
        bus.pacY = CW'(y);
    endtask

    task automatic model_update();
        logic [ND-1:0] hits;
        int n;
        int low;
        int dx;
        int dy;
        hits = '0;
        n = 0;
        low = -1;
        if (rst) begin
            m_show = '1; m_left = 0; m_pulse = 0; m_idx = 0; m_cnt = 0; m_all = 0;
        end else if (bus.level_restart) begin
            m_show = '1; m_left = 0; m_pulse = 0; m_cnt = 0; m_all = 0;
        end else if (bus.pause) begin
            m_pulse = 0; m_cnt = 0;
        end else begin
            for (int i = 0; i < ND; i++) begin
                dx = int'(bus.dotX[i*CW +: CW]) - int'(bus.pacX);
                dy = int'(bus.dotY[i*CW +: CW]) - int'(bus.pacY);
                if (dx < 0) dx = -dx;
                if (dy < 0) dy = -dy;
                if (m_show[i] && dx <= R && dy <= R) begin
                    hits[i] = 1'b1;
                    n++;
                    if (low < 0) low = i;
                end
            end
            if (n > 0) begin
                m_left = F;
                m_idx  = low;
            end else if (m_left > 0) begin
                m_left--;
            end
            m_show  = m_show & ~hits;
            m_all   = (m_show == '0) ? 1 : 0;
            m_pulse = (n > 0) ? 1 : 0;
            m_cnt   = n;
        end
    endtask

    task automatic compare_all();
        check("show",      32'(bus.show),      32'(m_show));
        check("freeze",    32'(bus.freeze),    (m_left > 0) ? 32'd1 : 32'd0);
        check("warn",      32'(bus.warn),      (m_left > 0 && m_left <= W) ? 32'd1 : 32'd0);
        check("eat_pulse", 32'(bus.eat_pulse), 32'(m_pulse));
        check("eat_count", 32'(bus.eat_count), 32'(m_cnt));
        check("eat_index", 32'(bus.eat_index), 32'(m_idx));
        check("all_eaten", 32'(bus.all_eaten), 32'(m_all));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    // Keeps stepping with pac parked until freeze drops, tallying freeze/warn cycles.
    task automatic run_out(inout int fr, inout int wr);
        int budget;
        budget = 100;
        while (bus.freeze === 1'b1 && budget > 0) begin
            step();
            if (bus.freeze === 1'b1) fr++;
            if (bus.warn === 1'b1) wr++;
            budget--;
        end
        if (budget == 0) check("freeze_timeout", 32'(bus.freeze), 32'd0);
    endtask

    task automatic restart_level();
        bus.level_restart = 1'b1;
        step();
        bus.level_restart = 1'b0;
    endtask

    task automatic home_dots();
        set_dot(0, 106, 94);
        set_dot(1, 300, 300);
        set_dot(2, 500, 500);
        set_dot(3, 700, 700);
    endtask

    initial begin
        int fr;
        int wr;
        int r;
        int k;
        int off;
        rst = 1'b1;
        bus.pause = 1'b0;
        bus.level_restart = 1'b0;
        home_dots();
        set_pac(PARK, PARK);
        m_show = '1; m_left = 0; m_pulse = 0; m_idx = 0; m_cnt = 0; m_all = 0;
        step();
        step();
        rst = 1'b0;
        step();

        // Single eat, then full frightened duration and warning tail.
        set_pac(100, 100);
        step();
        check("t1_show", 32'(bus.show), 32'b1110);
        check("t1_pulse", 32'(bus.eat_pulse), 32'd1);
        fr = (bus.freeze === 1'b1) ? 1 : 0;
        wr = (bus.warn === 1'b1) ? 1 : 0;
        set_pac(PARK, PARK);
        run_out(fr, wr);
        check("t1_freeze_len", 32'(fr), 32'd20);
        check("t1_warn_len", 32'(wr), 32'd5);

        // Near misses, including the screen-edge aliasing case.
        restart_level();
        set_dot(0, 107, 100);
        set_pac(100, 100);
        step();
        check("t2_miss_show", 32'(bus.show), 32'b1111);
        set_dot(0, 1020, 2);
        set_pac(2, 2);
        step();
        check("t2_edge_freeze", 32'(bus.freeze), 32'd0);
        home_dots();
        set_pac(PARK, PARK);

        // Two pellets eaten together.
        set_dot(1, 200, 200);
        set_dot(3, 203, 197);
        set_pac(200, 200);
        step();
        check("t3_show", 32'(bus.show), 32'b0101);
        check("t3_index", 32'(bus.eat_index), 32'd1);
        check("t3_count", 32'(bus.eat_count), 32'd2);
        set_pac(PARK, PARK);
        step();
        check("t3_single_pulse", 32'(bus.eat_pulse), 32'd0);
        fr = 0; wr = 0;
        run_out(fr, wr);
        home_dots();

        // Re-eat during warning restarts the full period.
        restart_level();
        set_pac(100, 100);
        step();
        set_pac(PARK, PARK);
        for (int i = 0; i < 15; i++) step();
        check("t4_in_warn", 32'(bus.warn), 32'd1);
        set_pac(500, 500);
        step();
        check("t4_warn_drop", 32'(bus.warn), 32'd0);
        fr = (bus.freeze === 1'b1) ? 1 : 0;
        wr = 0;
        set_pac(PARK, PARK);
        run_out(fr, wr);
        check("t4_freeze_len", 32'(fr), 32'd20);

        // Pause mid-frightened with Pac-Man over a visible pellet.
        restart_level();
        set_pac(100, 100);
        step();
        fr = 1; wr = 0;
        set_pac(PARK, PARK);
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.freeze === 1'b1) fr++;
        end
        bus.pause = 1'b1;
        set_pac(300, 300);
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.freeze === 1'b1) fr++;
        end
        check("t5_no_eat", 32'(bus.show), 32'b1110);
        bus.pause = 1'b0;
        set_pac(PARK, PARK);
        run_out(fr, wr);
        check("t5_freeze_len", 32'(fr), 32'd30);

        // Eat everything, then restart with a collision pending.
        restart_level();
        for (int i = 0; i < ND; i++) begin
            set_pac(int'(bus.dotX[i*CW +: CW]), int'(bus.dotY[i*CW +: CW]));
            step();
        end
        check("t6_all_eaten", 32'(bus.all_eaten), 32'd1);
        set_pac(100, 100);
        restart_level();
        check("t6_restart_show", 32'(bus.show), 32'b1111);
        check("t6_restart_freeze", 32'(bus.freeze), 32'd0);
        bus.level_restart = 1'b1;
        step();
        check("t6_restart_prio", 32'(bus.eat_pulse), 32'd0);
        bus.level_restart = 1'b0;
        step();
        set_pac(PARK, PARK);
        for (int i = 0; i < 17; i++) step();
        check("t6_pre_reset_warn", 32'(bus.warn), 32'd1);
        rst = 1'b1;
        step();
        check("t6_reset_freeze", 32'(bus.freeze), 32'd0);
        check("t6_reset_show", 32'(bus.show), 32'b1111);
        rst = 1'b0;

        // Random play against the model.
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 99);
            rst = (r == 0);
            bus.level_restart = (r >= 1 && r <= 3);
            bus.pause = (r >= 4 && r <= 13);
            if (bus.level_restart && $urandom_range(0, 1) == 1) begin
                for (int i = 0; i < ND; i++) set_dot(i, $urandom_range(0, 1023), $urandom_range(0, 1023));
            end
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, ND - 1);
                off = $urandom_range(0, 16);
                set_pac(int'(bus.dotX[k*CW +: CW]) + off - 8,
                        int'(bus.dotY[k*CW +: CW]) + $urandom_range(0, 16) - 8);
            end else begin
                set_pac($urandom_range(0, 1023), $urandom_range(0, 1023));
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/power_pellet_ctrl.md
Name: power_pellet_ctrl

Overview:
Manages NUM_DOTS power pellets for the maze. Each cycle it checks every visible pellet against Pac-Man's position and hides any pellet he touches. An eat starts a frightened-mode timer whose `freeze` output drives the ghost logic, with a warning phase before the timer expires. Re-eating during frightened mode restarts the timer, and a level restart re-arms every pellet.

Parameters:
- NUM_DOTS, 4, number of pellets tracked (1..16).
- COORD_W, 10, width of each X/Y coordinate.
- HIT_RADIUS, 6, collision half-window in pixels, inclusive, per axis.
- CNT_W, 28, width of the frightened-mode counter.
- FRIGHT_CYCLES, 268435455, total frightened duration in clocks (≤ 2^CNT_W−1, ≥ 2).
- WARN_CYCLES, 50000000, length of the final warning phase in clocks (< FRIGHT_CYCLES).

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset  in  1  synchronous, active-high reset.
- dotX  in  NUM_DOTS*COORD_W  packed pellet X coordinates; pellet i occupies bits [i*COORD_W +: COORD_W].
- dotY  in  NUM_DOTS*COORD_W  packed pellet Y coordinates, same packing.
- pacX  in  COORD_W  Pac-Man centre X.
- pacY  in  COORD_W  Pac-Man centre Y.
- pause  in  1  game paused; holds the timer and suppresses eats.
- level_restart  in  1  one-cycle pulse; re-shows all pellets and cancels frightened mode.
- show  out  NUM_DOTS  per-pellet visible flag.
- freeze  out  1  frightened mode active (FRIGHT or WARN).
- warn  out  1  warning phase active (WARN only).
- eat_pulse  out  1  one-cycle pulse on any eat.
- eat_index  out  $clog2(NUM_DOTS)  lowest index eaten on the pulse cycle; holds its value otherwise.
- eat_count  out  $clog2(NUM_DOTS+1)  number of pellets eaten on the pulse cycle; 0 otherwise.
- all_eaten  out  1  high when show == 0.

Behaviour:
- Clocking and reset: single clock. Reset is synchronous, active-high. Every output and state register is registered.
- Reset values: show = all 1s, freeze = 0, warn = 0, eat_pulse = 0, eat_index = 0, eat_count = 0, all_eaten = 0, counter = 0, state = IDLE.
- Collision for pellet i requires all of:
  - show[i] = 1, pause = 0, level_restart = 0;
  - |dotX_i − pacX| ≤ HIT_RADIUS and |dotY_i − pacY| ≤ HIT_RADIUS.
- Absolute difference: computed in COORD_W+1 bits with no wrap. Coordinates near 0 or near 2^COORD_W−1 must not alias, so pac = 2 with dot = 1020 is a miss.
- Latency: a collision sampled at edge n produces at edge n+1:
  - show[i] = 0, eat_pulse = 1, freeze = 1;
  - counter = FRIGHT_CYCLES−1.
- Simultaneous collisions: all colliding pellets clear in the same cycle, with a single eat_pulse. eat_index = lowest colliding index; eat_count = popcount of colliding pellets.
- A hidden pellet never collides again until a level restart or reset.
- State machine:
  - IDLE: freeze = 0, warn = 0. On collision → FRIGHT, counter loaded.
  - FRIGHT: counter decrements by 1 per cycle while pause = 0. When the next counter value < WARN_CYCLES → WARN.
  - WARN: freeze = 1, warn = 1. Counter keeps decrementing. In the cycle counter == 0 and pause = 0 → IDLE, and freeze/warn drop at that edge.
- Re-trigger: a collision while in FRIGHT or WARN reloads the counter to FRIGHT_CYCLES−1 and forces FRIGHT (warn = 0 next cycle). freeze stays high continuously, with no gap.
- Pause: the counter and state hold, no eats occur, and outputs hold. eat_pulse is still 0 during pause.
- level_restart:
  - Has priority over collision and over timer expiry in the same cycle.
  - Next cycle: show = all 1s, state = IDLE, counter = 0, freeze = warn = 0, eat_pulse = 0.
- Reset mid-frightened: all registers return to reset values at the next edge; no residual freeze.
- Total frightened duration: freeze is high for exactly FRIGHT_CYCLES clocks (pause = 0, no re-trigger). warn is high for the last WARN_CYCLES of those clocks.
- all_eaten: registered, and updates the same edge as show.

Test Plan:
All directed tests use NUM_DOTS=4, HIT_RADIUS=6, FRIGHT_CYCLES=20, WARN_CYCLES=5.
1. Reset, then pac = (100,100) with dot0 = (106,94) → next edge: show = 4'b1110, eat_pulse = 1, eat_index = 0, eat_count = 1, freeze = 1. Then freeze stays high exactly 20 cycles, and warn is high on the last 5 of them.
2. Dot at (107,100), pac at (100,100) → no eat; show stays 4'b1111, freeze = 0. Edge case: pac = (2,2) with dot = (1020,2) → no eat (no wrap aliasing).
3. Dots 1 and 3 both within the window in the same cycle → show = 4'b0101, single eat_pulse, eat_index = 1, eat_count = 2.
4. Eat dot0, then eat dot2 at cycle 17 of frightened mode (during WARN) → warn drops next cycle; freeze continuous; freeze lasts 20 further cycles from the second eat.
5. pause held 10 cycles mid-FRIGHT while pac overlaps a visible pellet → no eat, counter frozen; freeze extends by exactly 10 cycles after release.
6. Eat all 4 pellets → all_eaten = 1. Then level_restart pulsed together with a collision → show = 4'b1111, freeze = 0, eat_pulse = 0, all_eaten = 0. Separately, Reset mid-WARN → all outputs return to reset values next edge.
